// File: rtl/regfl_loader.sv
// Stream loader for a 4-entry register file: accepts writes, then replays all stored bytes on a dump request.
// Optional macro REGFL_LOADER_RETAIN_EN keeps the contents after a dump so it can be repeated.
module regfl_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dump,
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             rf_wr_e,
  output logic [1:0]       rf_wr_addr,
  output logic [WIDTH-1:0] rf_wr_data,
  output logic [1:0]       rf_rd_addr,
  input  logic [WIDTH-1:0] rf_rd_data
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DUMP = 1'b1;

  logic [0:0] r_state;
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;

  logic w_in_dump;
  logic w_in_ready;
  logic w_wr_acc;
  logic w_last;

  assign w_in_dump  = (r_state == ST_DUMP);
  assign w_in_ready = !w_in_dump && (r_count < 3'd4);
  assign w_wr_acc   = in_valid && w_in_ready;
  // count is at least 1 whenever DUMP is entered, so count-1 never wraps here
  assign w_last     = w_in_dump && ({1'b0, r_rd_ptr} == (r_count - 3'd1));

  assign in_ready   = w_in_ready;
  assign busy       = w_in_dump;
  assign out_valid  = w_in_dump;
  assign out_last   = w_last;
  assign rf_wr_e    = w_wr_acc;
  assign rf_wr_addr = r_wr_ptr;
  assign rf_wr_data = in_data;

  // read side: address the register file only while dumping
  always_comb begin
    rf_rd_addr = 2'd0;
    out_data   = {WIDTH{1'b0}};
    if (w_in_dump) begin
      rf_rd_addr = r_rd_ptr;
      out_data   = rf_rd_data;
    end else begin
      rf_rd_addr = 2'd0;
      out_data   = {WIDTH{1'b0}};
    end
  end

  // state, pointers and fill count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
            r_count  <= r_count + 3'd1;
          end
          // a write accepted in the same cycle makes an empty store dumpable
          if (dump && ((r_count != 3'd0) || w_wr_acc)) begin
            r_state  <= ST_DUMP;
            r_rd_ptr <= 2'd0;
          end
        end
        ST_DUMP: begin
          if (out_ready) begin
            if (w_last) begin
              r_state  <= ST_IDLE;
              r_rd_ptr <= 2'd0;
`ifdef REGFL_LOADER_RETAIN_EN
              r_count  <= r_count;
              r_wr_ptr <= r_wr_ptr;
`else
              r_count  <= 3'd0;
              r_wr_ptr <= 2'd0;
`endif
            end else begin
              r_rd_ptr <= r_rd_ptr + 2'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfl_loader.sv
// Self-checking bench for regfl_loader: directed vector table, hand sequences and random traffic
// checked against a queue-based model of the stored bytes.
module tb_regfl_loader;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       dump;
  logic       busy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       rf_wr_e;
  logic [1:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic [1:0] rf_rd_addr;
  logic [7:0] rf_rd_data;

  logic [7:0] rf_mem [4];

  int checks = 0;
  int errors = 0;

  // model: bytes held in the register file in write order, and dump progress
  logic [7:0] m_q[$];
  bit         m_dump;
  int         m_idx;

  regfl_loader #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dump(dump), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .rf_wr_e(rf_wr_e), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // attached register file
  always @(posedge clk) if (rf_wr_e) rf_mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data = rf_mem[rf_rd_addr];

  typedef struct {
    logic       rst, iv;
    logic [7:0] d;
    logic       dm, ordy;
    logic       e_irdy, e_busy, e_ov;
    logic [7:0] e_od;
    logic       e_last, e_we;
    logic [1:0] e_wa;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [7:0] d,
                       input logic dm, input logic ordy);
    rst = r; in_valid = iv; in_data = d; dump = dm; out_ready = ordy;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    m_q.delete();
    m_dump = 1'b0;
    m_idx  = 0;
  endtask

  // one cycle: drive, compare against the model before the edge, advance the model
  task automatic step(input logic r, input logic iv, input logic [7:0] d,
                      input logic dm, input logic ordy);
    bit e_irdy;
    bit e_we;
    drive(r, iv, d, dm, ordy);
    @(negedge clk);
    e_irdy = !m_dump && (m_q.size() < 4);
    e_we   = iv && e_irdy;
    chk("in_ready", in_ready, e_irdy);
    chk("busy", busy, m_dump);
    chk("out_valid", out_valid, m_dump);
    chk("out_last", out_last, m_dump && (m_idx == m_q.size() - 1));
    chk("rf_wr_e", rf_wr_e, e_we);
    chk("rf_rd_addr", rf_rd_addr, m_dump ? m_idx : 0);
    if (e_we) begin
      chk("rf_wr_addr", rf_wr_addr, m_q.size() % 4);
      chk("rf_wr_data", rf_wr_data, d);
    end
    if (m_dump) chk("out_data", out_data, m_q[m_idx]);
    if (r) begin
      m_q.delete();
      m_dump = 1'b0;
      m_idx  = 0;
    end else if (!m_dump) begin
      if (e_we) m_q.push_back(d);
      if (dm && m_q.size() > 0) begin
        m_dump = 1'b1;
        m_idx  = 0;
      end
    end else if (ordy) begin
      if (m_idx == m_q.size() - 1) begin
        m_dump = 1'b0;
        m_idx  = 0;
`ifndef REGFL_LOADER_RETAIN_EN
        m_q.delete();
`endif
      end else begin
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf_mem[i] = 8'h00;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_last", out_last, 0);
    chk("rst rf_wr_e", rf_wr_e, 0);
    chk("rst rf_rd_addr", rf_rd_addr, 0);
    @(posedge clk);
    #1;

    // rst iv d dm ordy | irdy busy ov od last we wa
    tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1};
    tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 2'd0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 2'd0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 2'd0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    tbl[9]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};
    tbl[10] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 2'd0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 2'd0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].dm, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_irdy);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("vec%0d out_last", i), out_last, tbl[i].e_last);
      chk($sformatf("vec%0d rf_wr_e", i), rf_wr_e, tbl[i].e_we);
      if (tbl[i].e_ov) chk($sformatf("vec%0d out_data", i), out_data, tbl[i].e_od);
      if (tbl[i].e_we) chk($sformatf("vec%0d rf_wr_addr", i), rf_wr_addr, tbl[i].e_wa);
      @(posedge clk);
      #1;
    end

    // five writes into a four-entry store, then dump
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // two-byte dump with downstream stalls
    do_reset();
    step(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hC2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // reset on the second byte of a four-byte dump
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hD0 + 8'(i), 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hE7, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // back-to-back dumps of the same contents
    do_reset();
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    end

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
